// File: rtl/regarr_pkg.sv
// Shared types and default sizes for the register-array responder.
// Build option REGARR_FAST_RSP_EN drops the EXEC state (see regarr_responder).
package regarr_pkg;

   localparam int REGARR_DW    = 8;
   localparam int REGARR_AW    = 4;
   localparam int REGARR_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   typedef struct packed {
      logic                 we;
      logic [REGARR_AW-1:0] addr;
      logic [REGARR_DW-1:0] wdata;
   } req_t;

endpackage

// File: rtl/regarr_storage.sv
// DEPTH x DW register array: async clear, one sync write port,
// one combinational read port and an address range flag.
module regarr_storage
   import regarr_pkg::*;
#(
   parameter int DW    = REGARR_DW,
   parameter int AW    = REGARR_AW,
   parameter int DEPTH = REGARR_DEPTH
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          in_range
);

   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];

   // full-width compare: no aliasing of addresses past DEPTH
   assign in_range = {1'b0, addr} < LIMIT;
   assign rdata    = in_range ? mem[addr] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we && in_range) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/regarr_responder.sv
// Valid/ready register-access responder, one response per request.
// REGARR_FAST_RSP_EN: access on the accepting edge, IDLE -> RESP.
module regarr_responder
   import regarr_pkg::*;
#(
   parameter int DW    = REGARR_DW,
   parameter int AW    = REGARR_AW,
   parameter int DEPTH = REGARR_DEPTH
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err
);

   state_e        state;
   logic          rdy;
   logic          accept;
   logic          st_we;
   logic          op_we;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_wdata;
   logic [DW-1:0] st_rdata;
   logic [DW-1:0] result;
   logic          in_range;

   assign req_ready = rdy;
   assign accept    = req_valid && rdy;

`ifdef REGARR_FAST_RSP_EN
   assign op_we    = req_we;
   assign st_addr  = req_addr;
   assign st_wdata = req_wdata;
   assign st_we    = accept && req_we;
`else
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cap_t;

   cap_t cap;

   assign op_we    = cap.we;
   assign st_addr  = cap.addr;
   assign st_wdata = cap.wdata;
   assign st_we    = (state == EXEC) && cap.we;
`endif

   // writes echo their data; out-of-range accesses return zero
   assign result = in_range ? (op_we ? st_wdata : st_rdata) : '0;

   regarr_storage #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk      (clk),
      .rstn     (rstn),
      .we       (st_we),
      .addr     (st_addr),
      .wdata    (st_wdata),
      .rdata    (st_rdata),
      .in_range (in_range)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rdy       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifndef REGARR_FAST_RSP_EN
         cap       <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  rdy <= 1'b0;
`ifdef REGARR_FAST_RSP_EN
                  rsp_valid <= 1'b1;
                  rsp_rdata <= result;
                  rsp_err   <= ~in_range;
                  state     <= RESP;
`else
                  cap <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                  state <= EXEC;
`endif
               end else begin
                  rdy <= 1'b1;
               end
            end
`ifndef REGARR_FAST_RSP_EN
            EXEC: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= result;
               rsp_err   <= ~in_range;
               state     <= RESP;
            end
`endif
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rdy       <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               rdy   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
